// File: rtl/wide_add_pkg.sv
// Shared types and sizing helpers for the multi-word add sequencer.
package wide_add_pkg;

    localparam int DEF_DATA_WID = 32;
    localparam int DEF_WORDS    = 4;
    localparam int DEF_ADD_LAT  = 2;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        LAST,
        DONE
    } state_t;

    // Bits needed to hold 0..n-1, never less than one.
    function automatic int idx_w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

endpackage

// File: rtl/wide_add_word_sel.sv
// Picks word k out of a flattened multi-word operand; with WIDE_ADD_SUB_EN
// the word can be inverted on the way out (subtract path).
module wide_add_word_sel
    import wide_add_pkg::*;
#(
    parameter int DATA_WID = DEF_DATA_WID,
    parameter int WORDS    = DEF_WORDS,
    localparam int KW      = idx_w(WORDS)
) (
    input  logic [DATA_WID*WORDS-1:0] op,
    input  logic [KW-1:0]             k,
`ifdef WIDE_ADD_SUB_EN
    input  logic                      inv,
`endif
    output logic [DATA_WID-1:0]       word
);

    logic [DATA_WID-1:0] raw;

    assign raw = op[int'(k)*DATA_WID +: DATA_WID];

`ifdef WIDE_ADD_SUB_EN
    assign word = raw ^ {DATA_WID{inv}};
`else
    assign word = raw;
`endif

endmodule

// File: rtl/wide_add_sequencer.sv
// Drives a pipelined word adder one slice at a time, LS word first, chaining
// carry-out to carry-in. Optional subtraction under WIDE_ADD_SUB_EN.
module wide_add_sequencer
    import wide_add_pkg::*;
#(
    parameter int DATA_WID = DEF_DATA_WID,
    parameter int WORDS    = DEF_WORDS,
    parameter int ADD_LAT  = DEF_ADD_LAT
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_WID*WORDS-1:0] in_a,
    input  logic [DATA_WID*WORDS-1:0] in_b,
    input  logic                      in_carry,
`ifdef WIDE_ADD_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_WID*WORDS-1:0] out_sum,
    output logic                      out_carry,
    output logic [DATA_WID-1:0]       adder_in1,
    output logic [DATA_WID-1:0]       adder_in2,
    output logic                      adder_carry_in,
    input  logic [DATA_WID-1:0]       adder_sum,
    input  logic                      adder_carry_out
);

    localparam int TOT = DATA_WID * WORDS;
    localparam int KW  = idx_w(WORDS);
    localparam int CW  = idx_w(ADD_LAT);

    state_t              state, state_nxt;
    logic [KW-1:0]       k, k_prev;
    logic [CW-1:0]       cnt;
    logic [TOT-1:0]      a_q, b_q;
    logic                carry_q;
    logic                k_last, k_inc, wait_end;
    logic [DATA_WID-1:0] word_a, word_b;

    assign k_last   = (k == KW'(WORDS - 1));
    assign k_prev   = k - KW'(1);
    // Counter is loaded with ADD_LAT-1 in ISSUE; leaving WAIT as it hits 0.
    assign wait_end = (cnt == CW'(1));

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        k_inc     = 1'b0;
        case (state)
            IDLE: if (in_valid) state_nxt = ISSUE;
            ISSUE: begin
                if (ADD_LAT == 1) begin
                    if (k_last) state_nxt = LAST;
                    else begin
                        state_nxt = ISSUE;
                        k_inc     = 1'b1;
                    end
                end else begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (wait_end) begin
                    if (k_last) state_nxt = LAST;
                    else begin
                        state_nxt = ISSUE;
                        k_inc     = 1'b1;
                    end
                end
            end
            LAST:    state_nxt = DONE;
            DONE:    if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

`ifdef WIDE_ADD_SUB_EN
    logic sub_q;

    always_ff @(posedge clock) begin
        if (reset)                          sub_q <= 1'b0;
        else if (state == IDLE && in_valid) sub_q <= in_sub;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            k         <= '0;
            cnt       <= '0;
            a_q       <= '0;
            b_q       <= '0;
            carry_q   <= 1'b0;
            out_sum   <= '0;
            out_carry <= 1'b0;
        end else begin
            if (k_inc) k <= k + KW'(1);
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q <= in_a;
                        b_q <= in_b;
                        k   <= '0;
`ifdef WIDE_ADD_SUB_EN
                        // Two's-complement subtract: ~B plus a forced carry-in.
                        carry_q <= in_sub ? 1'b1 : in_carry;
`else
                        carry_q <= in_carry;
`endif
                    end
                end
                ISSUE: begin
                    // Result of the previous slice lands exactly as this one issues.
                    if (k != '0) out_sum[int'(k_prev)*DATA_WID +: DATA_WID] <= adder_sum;
                    cnt <= CW'(ADD_LAT - 1);
                end
                WAIT: cnt <= cnt - CW'(1);
                LAST: begin
                    out_sum[(WORDS-1)*DATA_WID +: DATA_WID] <= adder_sum;
                    out_carry <= adder_carry_out;
                end
                default: ;
            endcase
        end
    end

    wide_add_word_sel #(
        .DATA_WID (DATA_WID),
        .WORDS    (WORDS)
    ) u_sel_a (
        .op   (a_q),
        .k    (k),
`ifdef WIDE_ADD_SUB_EN
        .inv  (1'b0),
`endif
        .word (word_a)
    );

    wide_add_word_sel #(
        .DATA_WID (DATA_WID),
        .WORDS    (WORDS)
    ) u_sel_b (
        .op   (b_q),
        .k    (k),
`ifdef WIDE_ADD_SUB_EN
        .inv  (sub_q),
`endif
        .word (word_b)
    );

    // The carry chain runs straight from the adder's output register back
    // into its input register, so no extra cycle per slice.
    always_comb begin
        adder_in1      = '0;
        adder_in2      = '0;
        adder_carry_in = 1'b0;
        if (state == ISSUE) begin
            adder_in1      = word_a;
            adder_in2      = word_b;
            adder_carry_in = (k == '0) ? carry_q : adder_carry_out;
        end
    end

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Self-checking bench: pipelined adder model, arithmetic reference model,
// per-cycle compare process, and directed literal cases.
module tb_wide_add_sequencer;
    import wide_add_pkg::*;

    localparam int DW      = DEF_DATA_WID;
    localparam int NW      = DEF_WORDS;
    localparam int AL      = DEF_ADD_LAT;
    localparam int TOT     = DW * NW;
    localparam int OUT_LAT = 2 + NW * AL;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [TOT-1:0] in_a = '0;
    logic [TOT-1:0] in_b = '0;
    logic           in_carry = 1'b0;
    logic           in_sub = 1'b0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [TOT-1:0] out_sum;
    logic           out_carry;
    logic [DW-1:0]  adder_in1, adder_in2, adder_sum;
    logic           adder_carry_in, adder_carry_out;

    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    wide_add_sequencer #(
        .DATA_WID (DW),
        .WORDS    (NW),
        .ADD_LAT  (AL)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_a            (in_a),
        .in_b            (in_b),
        .in_carry        (in_carry),
`ifdef WIDE_ADD_SUB_EN
        .in_sub          (in_sub),
`endif
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_sum         (out_sum),
        .out_carry       (out_carry),
        .adder_in1       (adder_in1),
        .adder_in2       (adder_in2),
        .adder_carry_in  (adder_carry_in),
        .adder_sum       (adder_sum),
        .adder_carry_out (adder_carry_out)
    );

    // Pipelined word adder: result readable AL cycles after inputs are presented.
    logic [DW-1:0] p_sum [AL];
    logic          p_co  [AL];

    always @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < AL; i++) begin
                p_sum[i] <= '0;
                p_co[i]  <= 1'b0;
            end
        end else begin
            {p_co[0], p_sum[0]} <= {1'b0, adder_in1} + {1'b0, adder_in2} + {{DW{1'b0}}, adder_carry_in};
            for (int i = 1; i < AL; i++) begin
                p_sum[i] <= p_sum[i-1];
                p_co[i]  <= p_co[i-1];
            end
        end
    end

    assign adder_sum       = p_sum[AL-1];
    assign adder_carry_out = p_co[AL-1];

    // Reference model: one operation in flight, result by plain arithmetic.
    int             cyc = 0;
    int             acc = 0;
    logic           active = 1'b0;
    logic [TOT-1:0] m_a = '0;
    logic [TOT-1:0] m_b = '0;
    logic           m_c = 1'b0;
    logic [TOT:0]   m_res = '0;
    wire            ov_exp = active && (cyc - acc >= OUT_LAT);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset) begin
            active <= 1'b0;
        end else if (!active) begin
            if (in_valid) begin
                active <= 1'b1;
                acc    <= cyc;
                m_a    <= in_a;
                if (in_sub) begin
                    m_b   <= ~in_b;
                    m_c   <= 1'b1;
                    m_res <= {(in_a >= in_b), in_a - in_b};
                end else begin
                    m_b   <= in_b;
                    m_c   <= in_carry;
                    m_res <= {1'b0, in_a} + {1'b0, in_b} + {{TOT{1'b0}}, in_carry};
                end
            end
        end else if (ov_exp && out_ready) begin
            active <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [TOT:0] act, input logic [TOT:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Carry into slice k of the low k words of A + B_eff + c.
    function automatic logic carry_into(input int k);
        logic [TOT:0] one, mask, s;
        if (k == 0) return m_c;
        one  = 1;
        mask = (one << (k * DW)) - one;
        s    = ({1'b0, m_a} & mask) + ({1'b0, m_b} & mask) + {{TOT{1'b0}}, m_c};
        return s[k * DW];
    endfunction

    always @(negedge clock) begin
        if (!reset) begin
            int d, k;
            logic [DW-1:0] e1, e2;
            logic          ec;
            chk("in_ready", {{TOT{1'b0}}, in_ready}, {{TOT{1'b0}}, !active});
            chk("out_valid", {{TOT{1'b0}}, out_valid}, {{TOT{1'b0}}, ov_exp});
            if (ov_exp) begin
                chk("out_sum", {1'b0, out_sum}, {1'b0, m_res[TOT-1:0]});
                chk("out_carry", {{TOT{1'b0}}, out_carry}, {{TOT{1'b0}}, m_res[TOT]});
            end
            d  = cyc - acc - 1;
            e1 = '0;
            e2 = '0;
            ec = 1'b0;
            if (active && d >= 0 && (d % AL) == 0 && (d / AL) < NW) begin
                k  = d / AL;
                e1 = m_a[k*DW +: DW];
                e2 = m_b[k*DW +: DW];
                ec = carry_into(k);
            end
            chk("adder_in1", {{(TOT-DW+1){1'b0}}, adder_in1}, {{(TOT-DW+1){1'b0}}, e1});
            chk("adder_in2", {{(TOT-DW+1){1'b0}}, adder_in2}, {{(TOT-DW+1){1'b0}}, e2});
            chk("adder_carry_in", {{TOT{1'b0}}, adder_carry_in}, {{TOT{1'b0}}, ec});
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_op(input logic [TOT-1:0] a, input logic [TOT-1:0] b, input logic c,
                         input logic sub, input int hold,
                         output logic [TOT-1:0] s, output logic co, output int lat);
        int t;
        in_a     = a;
        in_b     = b;
        in_carry = c;
        in_sub   = sub;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 60) begin
            step();
            t++;
        end
        chk("accept", {{TOT{1'b0}}, in_ready}, {{TOT{1'b0}}, 1'b1});
        step();
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            step();
            lat++;
        end
        chk("result_arrives", {{TOT{1'b0}}, out_valid}, {{TOT{1'b0}}, 1'b1});
        repeat (hold) step();
        s  = out_sum;
        co = out_carry;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    function automatic logic [TOT-1:0] rnd_wide();
        logic [TOT-1:0] v;
        for (int i = 0; i < NW; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    initial begin
        logic [TOT-1:0] s, ra, rb;
        logic           co, sb;
        int             lat;

        repeat (3) step();
        reset = 1'b0;
        step();
        chk("rst_out_valid", {{TOT{1'b0}}, out_valid}, '0);
        chk("rst_out_sum", {1'b0, out_sum}, '0);
        chk("rst_out_carry", {{TOT{1'b0}}, out_carry}, '0);
        chk("rst_in_ready", {{TOT{1'b0}}, in_ready}, {{TOT{1'b0}}, 1'b1});
        chk("rst_adder_in1", {{(TOT-DW+1){1'b0}}, adder_in1}, '0);

        do_op({TOT{1'b1}}, TOT'(1), 1'b0, 1'b0, 0, s, co, lat);
        chk("ones_plus_one_sum", {1'b0, s}, '0);
        chk("ones_plus_one_carry", {{TOT{1'b0}}, co}, {{TOT{1'b0}}, 1'b1});
        chk("latency", (TOT+1)'(lat), (TOT+1)'(10));

        do_op(128'h00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, TOT'(1), 1'b0, 1'b0, 0, s, co, lat);
        chk("ripple3_sum", {1'b0, s}, {1'b0, 128'h00000001_00000000_00000000_00000000});
        chk("ripple3_carry", {{TOT{1'b0}}, co}, '0);

        do_op('0, '0, 1'b1, 1'b0, 0, s, co, lat);
        chk("cin_only_sum", {1'b0, s}, (TOT+1)'(1));
        chk("cin_only_carry", {{TOT{1'b0}}, co}, '0);

        do_op(TOT'(100), TOT'(23), 1'b0, 1'b0, 5, s, co, lat);
        chk("held_sum", {1'b0, s}, (TOT+1)'(123));
        do_op(TOT'(3), TOT'(4), 1'b1, 1'b0, 0, s, co, lat);
        chk("b2b_sum", {1'b0, s}, (TOT+1)'(8));

        // Abandon an operation during WAIT of word 2 (accept at a, WAIT at a+6).
        in_a = rnd_wide(); in_b = rnd_wide(); in_carry = 1'b0; in_sub = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_out_valid", {{TOT{1'b0}}, out_valid}, '0);
        chk("midrst_out_sum", {1'b0, out_sum}, '0);
        chk("midrst_in_ready", {{TOT{1'b0}}, in_ready}, {{TOT{1'b0}}, 1'b1});
        do_op(TOT'(5), TOT'(7), 1'b0, 1'b0, 0, s, co, lat);
        chk("after_rst_sum", {1'b0, s}, (TOT+1)'(12));

`ifdef WIDE_ADD_SUB_EN
        do_op(TOT'(5), TOT'(7), 1'b0, 1'b1, 0, s, co, lat);
        chk("sub_neg_sum", {1'b0, s}, {1'b0, {(TOT-1){1'b1}}, 1'b0});
        chk("sub_neg_carry", {{TOT{1'b0}}, co}, '0);
        do_op(TOT'(7), TOT'(5), 1'b1, 1'b1, 0, s, co, lat);
        chk("sub_pos_sum", {1'b0, s}, (TOT+1)'(2));
        chk("sub_pos_carry", {{TOT{1'b0}}, co}, {{TOT{1'b0}}, 1'b1});
`endif

        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 2)) step();
            ra = rnd_wide();
            rb = ($urandom_range(0, 3) == 0) ? ~ra : rnd_wide();
`ifdef WIDE_ADD_SUB_EN
            sb = 1'($urandom_range(0, 1));
`else
            sb = 1'b0;
`endif
            do_op(ra, rb, 1'($urandom_range(0, 1)), sb, $urandom_range(0, 3), s, co, lat);
        end

        repeat (3) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/wide_add_sequencer.md
# wide_add_sequencer

Multi-word addition controller that sits directly upstream of the pipelined 32-bit carry-lookahead adder and also consumes its results. It accepts a WORDS×DATA_WID operand pair over a valid/ready handshake and issues one word slice to the adder at a time, least significant first. It feeds each registered carry-out back as the next slice's carry-in, then assembles the full sum and carry for a valid/ready consumer.

## Interface
- DATA_WID, 32, word width; must equal the adder's width.
- WORDS, 4, number of word slices per operation; must be ≥ 2.
- ADD_LAT, 2, adder latency in cycles, from the cycle inputs are presented to the cycle the result is readable; must be ≥ 1.

- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  operand pair offered.
- in_ready  out  1  block can accept; equals (state==IDLE).
- in_a  in  DATA_WID*WORDS  operand A; word k is bits [k*DATA_WID +: DATA_WID].
- in_b  in  DATA_WID*WORDS  operand B.
- in_carry  in  1  initial carry-in.
- out_valid  out  1  result held for the consumer.
- out_ready  in  1  consumer accepts.
- out_sum  out  DATA_WID*WORDS  full sum.
- out_carry  out  1  final carry-out.
- adder_in1  out  DATA_WID  to adder in1.
- adder_in2  out  DATA_WID  to adder in2.
- adder_carry_in  out  1  to adder carry_in.
- adder_sum  in  DATA_WID  from adder sum.
- adder_carry_out  in  1  from adder carry_out.

## Operation
- Reset values: state IDLE, k=0, out_valid 0, out_sum 0, out_carry 0, adder_in1/adder_in2/adder_carry_in 0. in_ready is 1 from the first cycle after reset.
- IDLE: on in_valid&&in_ready, latch in_a, in_b and in_carry into operand registers, set k=0, then go to ISSUE.
- ISSUE (1 cycle):
  - Drive adder_in1/adder_in2 with word k.
  - adder_carry_in = latched carry when k==0, otherwise adder_carry_out (combinational pass-through).
  - If k>0, capture adder_sum into out_sum word k-1.
  - Load wait counter with ADD_LAT-1. Go to WAIT, or skip WAIT when ADD_LAT==1.
- WAIT: decrement the counter each cycle. At 0: if k==WORDS-1 go to LAST, else k++ and go to ISSUE.
- LAST: capture adder_sum into word WORDS-1 and adder_carry_out into out_carry. Go to DONE.
- DONE: out_valid=1. out_sum and out_carry stay stable until out_ready. On out_ready go to IDLE; the new operand is accepted no earlier than the next cycle.
- Outside ISSUE, adder_in1/adder_in2/adder_carry_in are driven to 0.
- Arithmetic is modulo 2^(DATA_WID*WORDS). out_carry is bit DATA_WID*WORDS of A+B+in_carry.
- Reset mid-operation: the operation is abandoned, with no partial output and no out_valid. The adder shares the same reset, so no stale carry survives.

## Timing
- Accept at cycle a. ISSUE for word k occurs at cycle a+1+k*ADD_LAT. LAST is at a+1+WORDS*ADD_LAT. out_valid rises at a+2+WORDS*ADD_LAT, which is a+10 for the defaults.
- Throughput is one operation per WORDS*ADD_LAT+3 cycles when out_ready is held high.
- Word issue interval is exactly ADD_LAT cycles. The carry path is adder output register → adder input register, with no extra register.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - Adds port in_sub (in, 1), latched with the operands.
  - When in_sub=1, B words are inverted before issue and the initial carry is forced to 1, ignoring in_carry. out_sum = A−B.
  - out_carry is 1 when there is no borrow.
- WIDE_ADD_SUB_EN undefined: no in_sub port; addition only.

## Structure
- Package wide_add_pkg holds:
  - the state enum (IDLE, ISSUE, WAIT, LAST, DONE);
  - default DATA_WID/WORDS/ADD_LAT constants;
  - a log2 helper for the k and wait counter widths.
- One natural sub-module, wide_add_word_sel: selects word k from a flattened operand register, with optional inversion under WIDE_ADD_SUB_EN.

## Test plan
- A=all ones (128b), B=1, carry 0 → out_sum=0, out_carry=1, out_valid exactly at a+10.
- A=0x00000000_FFFFFFFF_FFFFFFFF_FFFFFFFF, B=1 → out_sum=0x00000001_00000000_00000000_00000000, out_carry=0. This checks the carry propagating through three words.
- A=B=0, in_carry=1 → out_sum=1, out_carry=0.
- out_ready held 0 for 5 cycles in DONE → out_valid, out_sum and out_carry stable and in_ready=0. Release → in_ready=1 next cycle, and a back-to-back op gives the correct result.
- reset pulsed for 1 cycle during WAIT of word 2 → next cycle out_valid=0, out_sum=0, in_ready=1. A fresh op 5+7 then yields 12.
- With WIDE_ADD_SUB_EN: 5−7 → out_sum=all ones except bit 0 (−2), out_carry=0. 7−5 → 2, out_carry=1.
